// File: rtl/exu_muldiv_unit_if.sv
// Handshake bundle between the EXU operand/writeback path and the RV32M mul/div unit.
// The EXU drives the master side and the unit the slave side.
interface exu_muldiv_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  modport master (
    output in_valid, in_op, in_rs1_data, in_rs2_data, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, busy
  );

  modport slave (
    input  in_valid, in_op, in_rs1_data, in_rs2_data, in_rd, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, busy
  );
endinterface

// File: rtl/exu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, operating on magnitudes with the sign applied at the end.
module exu_muldiv_unit (
  input  logic             clk,
  input  logic             rst,
  exu_muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic        r_neg;
  logic [5:0]  r_cnt;
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic [4:0]  r_out_rd;

  logic        w_accept, w_is_div, w_s1_signed, w_s2_signed, w_s1, w_s2;
  logic        w_div0, w_ovf, w_special, w_neg;
  logic [31:0] w_mag1, w_mag2, w_special_res;
  logic [32:0] w_sum;
  logic [63:0] w_mul_nxt, w_shl, w_div_nxt, w_acc_nxt, w_mul_full;
  logic        w_ge;
  logic [31:0] w_diff, w_mul_res, w_div_raw, w_div_res, w_final;
  logic        w_last;

  // Accept-time decode: operand signedness, magnitudes and early-out cases.
  always_comb begin
    w_accept      = bus.in_valid & bus.in_ready & ~bus.flush;
    w_is_div      = bus.in_op[2];
    w_s1_signed   = w_is_div ? ~bus.in_op[0] : (bus.in_op == 3'b001 || bus.in_op == 3'b010);
    w_s2_signed   = w_is_div ? ~bus.in_op[0] : (bus.in_op == 3'b001);
    w_s1          = w_s1_signed & bus.in_rs1_data[31];
    w_s2          = w_s2_signed & bus.in_rs2_data[31];
    w_mag1        = w_s1 ? -bus.in_rs1_data : bus.in_rs1_data;
    w_mag2        = w_s2 ? -bus.in_rs2_data : bus.in_rs2_data;
    w_neg         = (w_is_div && bus.in_op[1]) ? w_s1 : (w_s1 ^ w_s2);
    w_div0        = w_is_div & (bus.in_rs2_data == 32'd0);
    w_ovf         = w_is_div & ~bus.in_op[0] & (bus.in_rs1_data == 32'h8000_0000) &
                    (bus.in_rs2_data == 32'hFFFF_FFFF);
    w_special     = w_div0 | w_ovf;
    w_special_res = w_div0 ? (bus.in_op[1] ? bus.in_rs1_data : 32'hFFFF_FFFF)
                           : (bus.in_op[1] ? 32'd0 : 32'h8000_0000);
  end

  // One iteration step plus the final sign fix-up and result select.
  always_comb begin
    w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    w_mul_nxt  = {w_sum, r_acc[31:1]};
    w_shl      = {r_acc[62:0], 1'b0};
    // r_acc[63] is the 33rd remainder bit that falls out of the shift.
    w_ge       = {r_acc[63], w_shl[63:32]} >= {1'b0, r_b};
    w_diff     = w_shl[63:32] - r_b;
    w_div_nxt  = w_ge ? {w_diff, w_shl[31:1], 1'b1} : w_shl;
    w_acc_nxt  = r_op[2] ? w_div_nxt : w_mul_nxt;
    w_mul_full = r_neg ? -w_mul_nxt : w_mul_nxt;
    w_mul_res  = (r_op[1:0] == 2'b00) ? w_mul_full[31:0] : w_mul_full[63:32];
    w_div_raw  = r_op[1] ? w_div_nxt[63:32] : w_div_nxt[31:0];
    w_div_res  = r_neg ? -w_div_raw : w_div_raw;
    w_final    = r_op[2] ? w_div_res : w_mul_res;
    w_last     = (r_cnt == 6'd31);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (r_out_valid && bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush) w_state_nxt = S_IDLE;
  end

  always_comb begin
    bus.in_ready = (r_state == S_IDLE) & ~rst;
    bus.busy     = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= 3'd0;
      r_rd         <= 5'd0;
      r_acc        <= 64'd0;
      r_b          <= 32'd0;
      r_neg        <= 1'b0;
      r_cnt        <= 6'd0;
      r_out_valid  <= 1'b0;
      r_out_result <= 32'd0;
      r_out_rd     <= 5'd0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op  <= bus.in_op;
          r_rd  <= bus.in_rd;
          r_acc <= {32'd0, w_mag1};
          r_b   <= w_mag2;
          r_neg <= w_neg;
          r_cnt <= 6'd0;
          if (w_special) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_special_res;
            r_out_rd     <= bus.in_rd;
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (w_last) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_final;
            r_out_rd     <= r_rd;
          end
        end
        S_DONE: if (bus.out_ready) r_out_valid <= 1'b0;
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_rd     = r_out_rd;
endmodule

// File: tb/tb_exu_muldiv_unit.sv
// Bench for exu_muldiv_unit: directed table, handshake/flush/reset sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_exu_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exu_muldiv_unit_if bus();
  exu_muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    bit ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_op       = op;
    bus.in_rs1_data = a;
    bus.in_rs2_data = b;
    bus.in_rd       = rd;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // lat counts cycles after the accept edge; 1 = visible right after it.
  task automatic wait_out(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(op, a, b, rd);
    wait_out(lat);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", bus.out_result, exp);
    chk("out_rd", 32'(bus.out_rd), 32'(rd));
    @(posedge clk);
    #1;
    chk("out_valid_clear", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;

    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 33};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 33};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd6,  32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,         5'd9,  32'd14,        33};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,         5'd10, 32'd2,         33};
    tbl[8]  = '{3'd5, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd6, 32'd5,          32'd0,         5'd12, 32'd5,         1};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         1};

    bus.in_valid = 0; bus.in_op = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0;
    bus.in_rd = 0; bus.flush = 0; bus.out_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].lat);

    // Flush during a divide: result dropped, unit idle again next cycle.
    start_op(3'd4, 32'd1000, 32'd3, 5'd15);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    run_op(3'd4, 32'd1000, 32'hFFFF_FFFD, 5'd16, 32'hFFFF_FEB3, 33);

    // Flush coincident with in_valid: nothing accepted.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    bus.in_op = 3'd5; bus.in_rs1_data = 32'd5; bus.in_rs2_data = 32'd0; bus.in_rd = 5'd17;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("flush_acc_busy", 32'(bus.busy), 32'd0);
    seen = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1;
    end
    chk("flush_acc_no_valid", 32'(seen), 32'd0);

    // Backpressure: DONE held with stable outputs.
    bus.out_ready = 1'b0;
    start_op(3'd5, 32'd100, 32'd7, 5'd9);
    wait_out(lat);
    chk("bp_latency", 32'(lat), 32'd33);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_result", bus.out_result, 32'd14);
      chk("bp_rd", 32'(bus.out_rd), 32'd9);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of CALC.
    start_op(3'd0, 32'd12345, 32'd678, 5'd20);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", bus.out_result, 32'd0);
    chk("midrst_rd", 32'(bus.out_rd), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      rd = 5'($urandom_range(0, 31));
      run_op(op, a, b, rd, model(op, a, b), model_lat(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
